// File: rtl/sum_nbcc_seq.sv
// Digit-serial adder/subtractor: CHUNK bits per clock, LSB slice first.
// Registered carry between slices; start/busy/done handshake.
module sum_nbcc_seq #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             init,
    input  logic [WIDTH-1:0] xi,
    input  logic [WIDTH-1:0] yi,
    input  logic             ci,
    input  logic             sub,
    output logic [WIDTH-1:0] zi,
    output logic             co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NSLICE = WIDTH / CHUNK;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] part_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] zi_q;
    logic             co_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic [CHUNK:0]         slice_sum;
    logic [WIDTH+CHUNK-1:0] part_cat;
    logic [WIDTH-1:0]       part_d;
    logic                   carry_d;
    logic                   ovf_d;

    // Operands shift right each slice, so the active slice is always
    // the low CHUNK bits; the result fills in from the top.
    always_comb begin
        slice_sum = {1'b0, a_q[CHUNK-1:0]}
                  + {1'b0, b_q[CHUNK-1:0]}
                  + {{CHUNK{1'b0}}, carry_q};
        carry_d   = slice_sum[CHUNK];
        part_cat  = {slice_sum[CHUNK-1:0], part_q};
        part_d    = part_cat[WIDTH+CHUNK-1:CHUNK];
        ovf_d     = (a_q[CHUNK-1] == b_q[CHUNK-1])
                 && (slice_sum[CHUNK-1] != a_q[CHUNK-1]);
    end

    // Control FSM with registered datapath and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            zi_q    <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (init) begin
                        a_q     <= xi;
                        b_q     <= sub ? ~yi : yi;
                        carry_q <= sub ? ~ci : ci;
                        part_q  <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    part_q  <= part_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == LAST) begin
                        zi_q    <= part_d;
                        co_q    <= carry_d;
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign zi   = zi_q;
    assign co   = co_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
